// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets NUM_REQ requesters share one UART transmitter.
// It handles CTS gating, a transmitter acknowledge timeout, and a saturating frame counter.
module uart_tx_arbiter #(
    parameter int  NUM_REQ   = 4,
    parameter int  DATA_BITS = 8,
    parameter int  TIMEOUT   = 16,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         SysClk,
    input  logic                         Rst,
    input  logic [NUM_REQ-1:0]           Req,
    input  logic [NUM_REQ*DATA_BITS-1:0] Req_Data,
    output logic [NUM_REQ-1:0]           Grant,
    input  logic                         CTS,
    input  logic                         Tx_Busy,
    output logic                         Tx_Start,
    output logic [DATA_BITS-1:0]         Tx_Data,
    output logic [ID_W-1:0]              Active_Id,
    output logic                         Busy,
    output logic                         Timeout_Err,
    output logic [15:0]                  Frame_Count
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state, state_next;
    logic [ID_W-1:0]   last_id, winner, idx;
    logic [CNT_W-1:0]  wait_cnt;
    logic              arb_go, busy_ack, timeout_hit, frame_end;

    // The search runs from the farthest offset to the nearest one, so the nearest
    // asserted request after last_id overwrites all the others.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_id) + k) % NUM_REQ);
            if (Req[idx]) winner = idx;
        end
    end

    always_comb begin
        state_next  = state;
        arb_go      = 1'b0;
        busy_ack    = 1'b0;
        timeout_hit = 1'b0;
        frame_end   = 1'b0;
        Grant       = '0;
        Tx_Start    = 1'b0;
        Busy        = (state != IDLE);
        case (state)
            IDLE: begin
                if (|Req && CTS && !Tx_Busy) begin
                    arb_go     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                Grant[Active_Id] = 1'b1;
                Tx_Start         = 1'b1;
                state_next       = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (Tx_Busy) begin
                    busy_ack   = 1'b1;
                    state_next = WAIT_DONE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!Tx_Busy) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge SysClk) begin
        if (Rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge SysClk) begin
        if (Rst) begin
            Tx_Data     <= '0;
            Active_Id   <= '0;
            last_id     <= ID_W'(NUM_REQ - 1);
            wait_cnt    <= '0;
            Frame_Count <= '0;
            Timeout_Err <= 1'b0;
        end else begin
            Timeout_Err <= timeout_hit;
            if (arb_go) begin
                Tx_Data   <= Req_Data[winner*DATA_BITS +: DATA_BITS];
                Active_Id <= winner;
            end
            // START always precedes WAIT_BUSY, so the counter is clear on entry.
            if (state == START)          wait_cnt <= '0;
            else if (state == WAIT_BUSY) wait_cnt <= wait_cnt + CNT_W'(1);
            if (busy_ack && Frame_Count != 16'hFFFF) Frame_Count <= Frame_Count + 16'd1;
            if (timeout_hit || frame_end) last_id <= Active_Id;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a frame-level reference model is compared every cycle,
// with directed scenarios and randomized traffic on top of it.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int DB  = 8;
    localparam int TMO = 16;

    logic          SysClk = 1'b0;
    logic          Rst = 1'b1;
    logic [N-1:0]  Req = '0;
    logic [N*DB-1:0] Req_Data = '0;
    logic [N-1:0]  Grant;
    logic          CTS = 1'b0;
    logic          Tx_Busy = 1'b0;
    logic          Tx_Start;
    logic [DB-1:0] Tx_Data;
    logic [1:0]    Active_Id;
    logic          Busy;
    logic          Timeout_Err;
    logic [15:0]   Frame_Count;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .TIMEOUT(TMO)) dut (
        .SysClk(SysClk), .Rst(Rst), .Req(Req), .Req_Data(Req_Data), .Grant(Grant),
        .CTS(CTS), .Tx_Busy(Tx_Busy), .Tx_Start(Tx_Start), .Tx_Data(Tx_Data),
        .Active_Id(Active_Id), .Busy(Busy), .Timeout_Err(Timeout_Err),
        .Frame_Count(Frame_Count)
    );

    always #5 SysClk = ~SysClk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the frame in flight, described by its age and by whether it was acknowledged
    bit          m_in_frame = 1'b0;
    bit          m_acked = 1'b0;
    bit          m_terr = 1'b0;
    int          m_age = 0;
    int          m_wait = 0;
    int          m_last = N - 1;
    int          m_id = 0;
    int          m_count = 0;
    logic [DB-1:0] m_data = '0;

    task automatic model_step();
        m_terr = 1'b0;
        if (Rst) begin
            m_in_frame = 1'b0; m_acked = 1'b0; m_age = 0; m_wait = 0;
            m_id = 0; m_data = '0; m_count = 0; m_last = N - 1;
        end else if (!m_in_frame) begin
            if (Req != 0 && CTS && !Tx_Busy) begin
                for (int k = 1; k <= N; k++) begin
                    if (Req[(m_last + k) % N]) begin
                        m_id = (m_last + k) % N;
                        break;
                    end
                end
                m_data = Req_Data[m_id*DB +: DB];
                m_in_frame = 1'b1; m_age = 0; m_acked = 1'b0; m_wait = 0;
            end
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (!m_acked) begin
            if (Tx_Busy) begin
                m_acked = 1'b1;
                if (m_count < 65535) m_count++;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_in_frame = 1'b0; m_terr = 1'b1; m_last = m_id;
                end
            end
        end else if (!Tx_Busy) begin
            m_in_frame = 1'b0; m_last = m_id;
        end
    endtask

    initial forever begin
        @(posedge SysClk);
        model_step();
    end

    initial forever begin
        @(negedge SysClk);
        if (chk_en) begin
            logic [N-1:0] eg;
            eg = (m_in_frame && m_age == 0) ? N'(1 << m_id) : '0;
            chk("grant", 32'(Grant), 32'(eg));
            chk("tx_start", 32'(Tx_Start), 32'(m_in_frame && m_age == 0));
            chk("busy", 32'(Busy), 32'(m_in_frame));
            chk("tx_data", 32'(Tx_Data), 32'(m_data));
            chk("active_id", 32'(Active_Id), 32'(m_id));
            chk("frame_count", 32'(Frame_Count), 32'(m_count));
            chk("timeout_err", 32'(Timeout_Err), 32'(m_terr));
        end
    end

    // Transmitter model: raises Tx_Busy tx_delay cycles after Tx_Start, for tx_len cycles
    bit rand_mode = 1'b0;
    bit tx_dead = 1'b0;
    int tx_delay = 2;
    int tx_len = 10;

    initial forever begin
        @(negedge SysClk);
        if (Tx_Start === 1'b1) begin
            int d, l;
            bit dead;
            if (rand_mode) begin
                d = $urandom_range(1, 4); l = $urandom_range(1, 6);
                dead = ($urandom_range(0, 9) == 0);
            end else begin
                d = tx_delay; l = tx_len; dead = tx_dead;
            end
            if (!dead) begin
                repeat (d) @(posedge SysClk);
                #1 Tx_Busy = 1'b1;
                repeat (l) @(posedge SysClk);
                #1 Tx_Busy = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge SysClk); #1 Rst = 1'b1;
        @(posedge SysClk); #1 Rst = 1'b0;
    endtask

    task automatic wait_quiet();
        int n = 0;
        while ((Tx_Busy || Busy) && n < 100) begin
            @(posedge SysClk); #1;
            n++;
        end
        chk("quiet_bound", 32'(Tx_Busy || Busy), 32'd0);
    endtask

    task automatic wait_tx_start();
        int n = 0;
        do begin
            @(negedge SysClk);
            n++;
        end while (Tx_Start !== 1'b1 && n < 100);
        chk("tx_start_bound", 32'(Tx_Start), 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge SysClk);
            n++;
        end while (Busy !== 1'b0 && n < 100);
        chk("idle_bound", 32'(Busy), 32'd0);
    endtask

    initial begin
        int exp_ids [5] = '{0, 1, 2, 3, 0};
        int n;
        bit bad;
        repeat (2) @(posedge SysClk);
        #1 Rst = 1'b0;
        chk_en = 1'b1;

        // Single request, transmitter acknowledges 2 cycles after Tx_Start
        Req = 4'b0001; Req_Data = {8'h13, 8'h12, 8'h11, 8'hA5}; CTS = 1'b1;
        @(negedge SysClk);
        chk("single_pre_grant", 32'(Grant), 32'h0);
        @(posedge SysClk); #1;
        @(negedge SysClk);
        chk("single_grant", 32'(Grant), 32'h1);
        chk("single_start", 32'(Tx_Start), 32'h1);
        chk("single_data", 32'(Tx_Data), 32'hA5);
        @(posedge SysClk); #1 Req = '0;
        wait_idle();
        chk("single_count", 32'(Frame_Count), 32'd1);

        // All requesters held: strict rotation from requester 0
        wait_quiet(); do_reset();
        Req = 4'b1111; Req_Data = {8'h13, 8'h12, 8'h11, 8'h10};
        tx_delay = 1; tx_len = 2;
        for (int i = 0; i < 5; i++) begin
            wait_tx_start();
            chk("rr_grant", 32'(Grant), 32'(1 << exp_ids[i]));
            chk("rr_data", 32'(Tx_Data), 32'h10 + 32'(exp_ids[i]));
        end
        @(posedge SysClk); #1 Req = '0;

        // CTS low holds off the grant
        wait_quiet(); do_reset();
        CTS = 1'b0; Req = 4'b0100;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge SysClk);
            if (Grant != 0) bad = 1'b1;
        end
        chk("cts_block", 32'(bad), 32'd0);
        @(posedge SysClk); #1 CTS = 1'b1;
        @(negedge SysClk);
        chk("cts_same_cycle", 32'(Grant), 32'h0);
        @(negedge SysClk);
        chk("cts_grant", 32'(Grant), 32'h4);
        @(posedge SysClk); #1 Req = '0;

        // Dead transmitter: timeout latency, count unchanged, rotation advances
        wait_quiet(); do_reset();
        tx_dead = 1'b1; tx_delay = 2; tx_len = 10; Req = 4'b0011;
        wait_tx_start();
        chk("to_first_grant", 32'(Grant), 32'h1);
        n = 0;
        do begin
            @(negedge SysClk);
            n++;
        end while (Timeout_Err !== 1'b1 && n < 40);
        chk("to_latency", 32'(n), 32'd17);
        chk("to_count", 32'(Frame_Count), 32'd0);
        wait_tx_start();
        chk("to_next_grant", 32'(Grant), 32'h2);
        @(posedge SysClk); #1 Req = '0; tx_dead = 1'b0;
        wait_idle();

        // Reset during WAIT_DONE while serving requester 2
        wait_quiet(); do_reset();
        Req = 4'b0100;
        wait_tx_start();
        chk("rst_active", 32'(Active_Id), 32'd2);
        repeat (5) @(negedge SysClk);
        chk("rst_busy_before", 32'(Busy), 32'd1);
        @(posedge SysClk); #1 Rst = 1'b1; Req = 4'b0101;
        @(posedge SysClk); #1 Rst = 1'b0;
        @(negedge SysClk);
        chk("rst_outputs", {Grant, Tx_Start, Busy, Timeout_Err, Tx_Data, Active_Id, Frame_Count}, 32'd0);
        wait_tx_start();
        chk("rst_next_grant", 32'(Grant), 32'h1);
        @(posedge SysClk); #1 Req = '0;

        // Random traffic against the model
        wait_quiet();
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge SysClk); #1;
            Req      = N'($urandom) & N'($urandom);
            Req_Data = $urandom;
            CTS      = ($urandom_range(0, 9) != 0);
            Rst      = ($urandom_range(0, 299) == 0);
        end
        @(posedge SysClk); #1 Rst = 1'b0; Req = '0;
        repeat (30) @(posedge SysClk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter, range 2..8.
REQ-002 The block SHALL have parameter DATA_BITS, default 8: transmit data width, equal to the UART DATA_BITS.
REQ-003 The block SHALL have parameter TIMEOUT, default 16: SysClk cycles allowed for the transmitter to assert Tx_Busy after Tx_Start.
REQ-004 The block SHALL have parameter ID_W = $clog2(NUM_REQ) (derived, not overridable).
REQ-005 The block SHALL have one clock and a synchronous active-high reset: SysClk  in  1  system clock, sole clock, all state on rising edge.
REQ-006 Rst  in  1  reset, synchronous, active-high.
REQ-007 Req  in  NUM_REQ  per-requester transmit request, level.
REQ-008 Req_Data  in  NUM_REQ*DATA_BITS  requester i data at [i*DATA_BITS +: DATA_BITS].
REQ-009 Grant  out  NUM_REQ  one-hot, one-cycle acknowledge that the requester's data was captured.
REQ-010 CTS  in  1  clear-to-send, 1 = remote ready; gates new grants only.
REQ-011 Tx_Busy  in  1  transmitter busy, from the UART.
REQ-012 Tx_Start  out  1  one-cycle write strobe to the UART transmitter.
REQ-013 Tx_Data  out  DATA_BITS  data to the transmitter, held stable from Tx_Start until the return to IDLE.
REQ-014 Active_Id  out  ID_W  index of the requester currently being served.
REQ-015 Busy  out  1  high whenever the state is not IDLE.
REQ-016 Timeout_Err  out  1  one-cycle pulse when the transmitter fails to acknowledge Tx_Start.
REQ-017 Frame_Count  out  16  frames accepted by the transmitter, saturating.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-019 In IDLE the FSM SHALL arbitrate only when all of the following hold on the same edge: |Req=1, CTS=1, Tx_Busy=0.
- Otherwise it SHALL stay in IDLE.
REQ-020 Arbitration SHALL be round-robin.
- Search order: Last_Id+1, Last_Id+2, ... wrapping modulo NUM_REQ, ending at Last_Id.
- The first asserted Req in that order SHALL win.
REQ-021 On the arbitration edge the block SHALL:
- register Tx_Data <= winner's Req_Data;
- register Active_Id <= winner index;
- go to START.
REQ-022 In START, Grant[Active_Id]=1 and Tx_Start=1 for exactly one cycle; both appear one cycle after the request is sampled; next state WAIT_BUSY.
REQ-023 A requester still asserting Req in the cycle after its Grant SHALL be treated as a new request.
REQ-024 In WAIT_BUSY:
- Tx_Busy=1 -> WAIT_DONE, and Frame_Count increments unless it equals 0xFFFF.
- TIMEOUT cycles elapse with Tx_Busy=0 -> Timeout_Err pulses one cycle, state returns to IDLE.
REQ-025 The WAIT_BUSY cycle counter SHALL clear on entry to WAIT_BUSY and SHALL be wide enough to count to TIMEOUT.
REQ-026 In WAIT_DONE the FSM SHALL wait for Tx_Busy=0, then go to IDLE.
REQ-027 Last_Id SHALL update to Active_Id on every exit to IDLE, whether after a completed frame or a timeout.
REQ-028 CTS falling during START, WAIT_BUSY or WAIT_DONE SHALL NOT abort the frame; it blocks only the next arbitration.
REQ-029 Tx_Data and Active_Id SHALL hold their values in IDLE until the next arbitration.
REQ-030 Busy SHALL be high in every state except IDLE.
REQ-031 Grant SHALL be zero in every state except START.
REQ-032 Tx_Start SHALL be zero in every state except START.
REQ-033 Timeout_Err SHALL be zero except for its single-cycle pulse.

Reset
REQ-034 When Rst=1 on an edge, in any state including mid-frame, the block SHALL set:
- state IDLE;
- Grant=0, Tx_Start=0, Timeout_Err=0, Busy=0;
- Tx_Data=0, Active_Id=0, Frame_Count=0, timeout counter=0;
- Last_Id=NUM_REQ-1, so requester 0 has first priority.
REQ-035 Rst SHALL take precedence over every other input on the same edge.

Verification
REQ-036 Reset, then Req=4'b0001, Req_Data[7:0]=8'hA5, CTS=1; a transmitter model raises Tx_Busy 2 cycles after Tx_Start for 10 cycles -> Grant=4'b0001 and Tx_Start one cycle later, Tx_Data=8'hA5, Frame_Count=1, Busy low after Tx_Busy falls.
REQ-037 Req=4'b1111 held continuously with data 8'h10/8'h11/8'h12/8'h13 -> grants in order 0,1,2,3,0 and Tx_Data sequence 10,11,12,13,10.
REQ-038 CTS=0 with Req=4'b0100 -> no Grant for 20 cycles; set CTS=1 -> Grant=4'b0100 on the following cycle.
REQ-039 Tx_Busy tied to 0 -> Timeout_Err pulses exactly 16 cycles after entering WAIT_BUSY, Frame_Count unchanged, next grant goes to the following requester.
REQ-040 Rst asserted during WAIT_DONE with Active_Id=2 -> next cycle state IDLE, all outputs 0, and a subsequent Req=4'b0101 is granted to requester 0 first.
